// File: rtl/mem_sramlike_ctrl.sv
// Data-side SRAM-like bus master for the memory stage.
// One bus transaction per load/store, pipeline stalled until it completes.
module mem_sramlike_ctrl #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  mem_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] bad_vaddr_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic        cancel;
    logic [1:0]  off_q;
    logic [2:0]  type_q;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        rw;
    logic        misaligned;
    logic        exc;
    logic        start;
    logic [1:0]  size_c;
    logic [31:0] lane_c;
    logic [31:0] addr_map;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_c;

    // Decode access width, alignment, exceptions and the start condition
    always_comb begin
        is_byte    = (mem_type_i[2:1] == 2'b00);
        is_half    = (mem_type_i[2:1] == 2'b01);
        is_word    = !is_byte && !is_half;
        rw         = mem_read_i | mem_write_i;
        misaligned = (is_half & addr_i[0]) | (is_word & (|addr_i[1:0]));
        exc        = en_i & rw & !flush_i & misaligned;
        adel_o     = exc & !mem_write_i;
        ades_o     = exc & mem_write_i;
        bad_vaddr_o = exc ? addr_i : 32'h0;
        start      = (state == S_IDLE) & en_i & rw & !misaligned & !flush_i;
        stall_o    = start | (state == S_REQ) | (state == S_WAIT);
        size_c     = 2'd2;
        lane_c     = wdata_i;
        unique case (1'b1)
            is_byte: begin
                size_c = 2'd0;
                lane_c = {4{wdata_i[7:0]}};
            end
            is_half: begin
                size_c = 2'd1;
                lane_c = {2{wdata_i[15:0]}};
            end
            default: begin
                size_c = 2'd2;
                lane_c = wdata_i;
            end
        endcase
        if (MAP_KSEG && addr_i[31:30] == 2'b10)
            addr_map = {3'b000, addr_i[28:0]};
        else
            addr_map = addr_i;
    end

    // Pick the addressed byte/half from the bus word and extend it
    always_comb begin
        rd_byte = data_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (type_q)
            3'b000:  load_c = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_c = {24'h0, rd_byte};
            3'b010:  load_c = {{16{rd_half[15]}}, rd_half};
            3'b011:  load_c = {16'h0, rd_half};
            default: load_c = data_rdata;
        endcase
    end

    // Transaction FSM with registered bus and result outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cancel        <= 1'b0;
            off_q         <= 2'b00;
            type_q        <= 3'b000;
            rdata_o       <= 32'h0;
            rdata_valid_o <= 1'b0;
            data_req      <= 1'b0;
            data_wr       <= 1'b0;
            data_size     <= 2'd0;
            data_addr     <= 32'h0;
            data_wdata    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQ;
                        data_req   <= 1'b1;
                        data_wr    <= mem_write_i;
                        data_size  <= size_c;
                        data_addr  <= addr_map;
                        data_wdata <= lane_c;
                        off_q      <= addr_i[1:0];
                        type_q     <= mem_type_i;
                        cancel     <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            if (flush_i) begin
                                state <= S_IDLE;
                            end else begin
                                state         <= S_DONE;
                                rdata_valid_o <= !data_wr;
                                if (!data_wr)
                                    rdata_o <= load_c;
                            end
                        end else begin
                            state  <= S_WAIT;
                            cancel <= flush_i;
                        end
                    end else if (flush_i) begin
                        state    <= S_IDLE;
                        data_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (cancel || flush_i) begin
                            state <= S_IDLE;
                        end else begin
                            state         <= S_DONE;
                            rdata_valid_o <= !data_wr;
                            if (!data_wr)
                                rdata_o <= load_c;
                        end
                        cancel <= 1'b0;
                    end else if (flush_i) begin
                        cancel <= 1'b1;
                    end
                end
                default: begin
                    if (flush_i || !pipe_stall_i) begin
                        state         <= S_IDLE;
                        rdata_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
